// File: rtl/dma_mem2sdram.sv
// Memory-to-SDRAM write-back DMA channel: reads 256-bit lines from memory 1 or 2
// and unpacks each line into four 64-bit SDRAM writes, least-significant word first.
module dma_mem2sdram #(
  parameter logic [5:0] MEM_ADDR_STEP = 6'd16
) (
  input  logic         clk_h,
  input  logic         rst_h,
  input  logic         start,
  input  logic         mem_sel_in,
  input  logic [5:0]   latch_mem_addr,
  input  logic [7:0]   latch_sdram_addr,
  input  logic [5:0]   num_lines,
  input  logic         memory1_ready,
  input  logic         memory2_ready,
  input  logic         mem_valid,
  input  logic [255:0] mem_data_in,
  input  logic         sdram_ready,
  output logic         mem_selecter,
  output logic [1:0]   mem_enable,
  output logic [5:0]   mem1_addr_out,
  output logic [5:0]   mem2_addr_out,
  output logic [1:0]   sdram_enable,
  output logic [7:0]   sdram_addr_out,
  output logic [63:0]  data_sdram_out,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {IDLE, MREQ, MWAIT, SWR, DONE} state_t;

  state_t         state_reg;
  logic           sel_reg;
  logic [5:0]     mem_addr_reg;
  logic [7:0]     sdram_addr_reg;
  logic [5:0]     lines_left_reg;
  logic [255:0]   line_reg;
  logic [1:0]     idx_reg;
  logic           sel_ready;
  logic [63:0]    line_word [4];

  assign sel_ready = sel_reg ? memory2_ready : memory1_ready;

  for (genvar gi = 0; gi < 4; gi++) begin : g_word
    assign line_word[gi] = line_reg[64*gi +: 64];
  end

  always_ff @(posedge clk_h) begin
    if (rst_h) begin
      state_reg      <= IDLE;
      sel_reg        <= 1'b0;
      mem_addr_reg   <= '0;
      sdram_addr_reg <= '0;
      lines_left_reg <= '0;
      line_reg       <= '0;
      idx_reg        <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            sel_reg        <= mem_sel_in;
            mem_addr_reg   <= latch_mem_addr;
            sdram_addr_reg <= latch_sdram_addr;
            lines_left_reg <= num_lines;
            state_reg      <= (num_lines == 6'd0) ? DONE : MREQ;
          end
        end
        MREQ: begin
          if (sel_ready) state_reg <= MWAIT;
        end
        MWAIT: begin
          if (mem_valid) begin
            line_reg  <= mem_data_in;
            idx_reg   <= 2'd0;
            state_reg <= SWR;
          end
        end
        SWR: begin
          if (sdram_ready) begin
            sdram_addr_reg <= sdram_addr_reg + 8'd1;
            idx_reg        <= idx_reg + 2'd1;
            // Last word of the line: either finish or fetch the next line.
            if (idx_reg == 2'd3) begin
              lines_left_reg <= lines_left_reg - 6'd1;
              if (lines_left_reg == 6'd1) begin
                state_reg <= DONE;
              end else begin
                mem_addr_reg <= mem_addr_reg + MEM_ADDR_STEP;
                state_reg    <= MREQ;
              end
            end
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mem_selecter   = sel_reg;
  assign mem_enable     = (state_reg == MREQ && sel_ready) ? 2'b01 : 2'b00;
  assign mem1_addr_out  = sel_reg ? 6'd0 : mem_addr_reg;
  assign mem2_addr_out  = sel_reg ? mem_addr_reg : 6'd0;
  assign sdram_enable   = (state_reg == SWR) ? 2'b10 : 2'b00;
  assign sdram_addr_out = sdram_addr_reg;
  assign data_sdram_out = line_word[idx_reg];
  assign busy           = (state_reg != IDLE);
  assign done           = (state_reg == DONE);

endmodule

// File: tb/tb_dma_mem2sdram.sv
// Bench for dma_mem2sdram: directed and randomized transfers checked against an
// expected list of memory requests and SDRAM writes built from the transfer parameters.
module tb_dma_mem2sdram;

  localparam logic [5:0] STEP = 6'd16;

  logic         clk_h = 1'b0;
  logic         rst_h, start, mem_sel_in;
  logic [5:0]   latch_mem_addr, num_lines;
  logic [7:0]   latch_sdram_addr;
  logic         memory1_ready, memory2_ready, mem_valid, sdram_ready;
  logic [255:0] mem_data_in;
  logic         mem_selecter, busy, done;
  logic [1:0]   mem_enable, sdram_enable;
  logic [5:0]   mem1_addr_out, mem2_addr_out;
  logic [7:0]   sdram_addr_out;
  logic [63:0]  data_sdram_out;

  int errors = 0;
  int checks = 0;

  dma_mem2sdram #(.MEM_ADDR_STEP(STEP)) dut (
    .clk_h(clk_h), .rst_h(rst_h), .start(start), .mem_sel_in(mem_sel_in),
    .latch_mem_addr(latch_mem_addr), .latch_sdram_addr(latch_sdram_addr),
    .num_lines(num_lines), .memory1_ready(memory1_ready), .memory2_ready(memory2_ready),
    .mem_valid(mem_valid), .mem_data_in(mem_data_in), .sdram_ready(sdram_ready),
    .mem_selecter(mem_selecter), .mem_enable(mem_enable), .mem1_addr_out(mem1_addr_out),
    .mem2_addr_out(mem2_addr_out), .sdram_enable(sdram_enable),
    .sdram_addr_out(sdram_addr_out), .data_sdram_out(data_sdram_out),
    .busy(busy), .done(done)
  );

  always #5 clk_h = ~clk_h;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    start = 1'b0; mem_sel_in = 1'b0; latch_mem_addr = '0; latch_sdram_addr = '0;
    num_lines = '0; memory1_ready = 1'b0; memory2_ready = 1'b0; mem_valid = 1'b0;
    mem_data_in = '0; sdram_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_enables"}, {mem_enable, sdram_enable}, 4'b0);
    check({tag, "_addrs"}, {mem1_addr_out, mem2_addr_out, sdram_addr_out}, 20'b0);
    check({tag, "_data"}, data_sdram_out, 64'b0);
    check({tag, "_flags"}, {mem_selecter, busy, done}, 3'b0);
  endtask

  function automatic logic [255:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // One transfer. Directed mode: memory stalls for the first mstall cycles, SDRAM
  // stalls sstall cycles on write sword, and start is pulsed during busy.
  task automatic run_xfer(input logic sel, input logic [5:0] maddr, input logic [7:0] saddr,
                          input logic [5:0] n, input bit rnd, input bit fixed0,
                          input logic [255:0] line0, input int mstall, input int sword,
                          input int sstall, input int exp_cyc);
    logic [7:0]   qa[$];
    logic [63:0]  qd[$];
    logic [5:0]   next_maddr = maddr;
    logic [255:0] ln, pline = '0;
    logic [7:0]   pa = '0;
    logic [63:0]  pd = '0;
    logic         sel_rdy = 1'b0;
    bit           pend = 0, stalled = 0;
    int           reqs = 0, k = 0, cyc = 0, sused = 0, dly = 0, dones = 0, done_cyc = -1;

    @(posedge clk_h); #1;
    start = 1'b1; mem_sel_in = sel; latch_mem_addr = maddr;
    latch_sdram_addr = saddr; num_lines = n;
    @(posedge clk_h);
    while (1) begin
      #1;
      start            = rnd ? 1'($urandom) : 1'(cyc % 2);
      mem_sel_in       = 1'($urandom);
      latch_mem_addr   = 6'($urandom);
      latch_sdram_addr = 8'($urandom);
      num_lines        = 6'($urandom);
      sel_rdy = rnd ? ($urandom_range(0, 3) != 0) : (cyc >= mstall);
      if (sel) begin memory2_ready = sel_rdy; memory1_ready = 1'($urandom); end
      else     begin memory1_ready = sel_rdy; memory2_ready = 1'($urandom); end
      if (pend) begin
        if (dly == 0) begin mem_valid = 1'b1; mem_data_in = pline; pend = 0; end
        else begin dly--; mem_valid = 1'b0; mem_data_in = rand_line(); end
      end else begin
        mem_valid   = rnd ? 1'($urandom) : 1'b0;
        mem_data_in = rand_line();
      end
      sdram_ready = rnd ? ($urandom_range(0, 2) != 0) : !(k == sword && sused < sstall);

      @(negedge clk_h);
      check("busy_in_xfer", busy, 1'b1);
      if (mem_enable == 2'b01) begin
        check("req_needs_ready", sel_rdy, 1'b1);
        check("req_addr", sel ? mem2_addr_out : mem1_addr_out, next_maddr);
        check("unsel_port_zero", sel ? mem1_addr_out : mem2_addr_out, 6'd0);
        ln = (fixed0 && reqs == 0) ? line0 : rand_line();
        for (int j = 0; j < 4; j++) begin
          qa.push_back(8'(saddr + 8'(4 * reqs + j)));
          qd.push_back(ln[64*j +: 64]);
        end
        pline = ln; pend = 1; dly = rnd ? $urandom_range(0, 2) : 0;
        reqs++; next_maddr = next_maddr + STEP;
      end
      if (sdram_enable == 2'b10) begin
        if (stalled) begin
          check("stall_addr_stable", sdram_addr_out, pa);
          check("stall_data_stable", data_sdram_out, pd);
        end
        if (sdram_ready) begin
          if (qa.size() == 0) check("extra_write", 1'b1, 1'b0);
          else begin
            check("wr_addr", sdram_addr_out, qa.pop_front());
            check("wr_data", data_sdram_out, qd.pop_front());
          end
          k++; stalled = 0;
        end else begin
          stalled = 1; pa = sdram_addr_out; pd = data_sdram_out;
          if (k == sword) sused++;
        end
      end else stalled = 0;
      if (done) begin dones++; done_cyc = cyc; end
      if (dones != 0 || cyc >= 400) break;
      @(posedge clk_h);
      cyc++;
    end

    quiet();
    check("done_seen", dones, 1);
    check("req_count", reqs, n);
    check("writes_left", qa.size(), 0);
    if (exp_cyc >= 0) check("done_cycle", done_cyc, exp_cyc);
    @(posedge clk_h);
    @(negedge clk_h);
    check("idle_flags", {busy, done, mem_enable, sdram_enable}, 6'b0);
    check("hold_sdram_addr", sdram_addr_out, 8'(saddr + 8'(4 * n)));
    if (n != 0) begin
      check("hold_mem_addr", sel ? mem2_addr_out : mem1_addr_out, 6'(next_maddr - STEP));
      check("hold_unsel_zero", sel ? mem1_addr_out : mem2_addr_out, 6'd0);
    end
    $display("xfer sel=%0d maddr=%0d saddr=%0h lines=%0d reqs=%0d done_cycle=%0d errors=%0d",
             sel, maddr, saddr, n, reqs, done_cyc, errors);
  endtask

  initial begin
    logic [255:0] l1;
    l1 = {64'h4, 64'h3, 64'h2, 64'h1};
    quiet();
    rst_h = 1'b1;
    repeat (2) @(posedge clk_h);
    #1 rst_h = 1'b0;
    @(negedge clk_h);
    check_all_zero("reset");

    run_xfer(1'b0, 6'd5, 8'h10, 6'd1, 0, 1, l1, 0, -1, 0, 6);

    // Idle reset after a transfer clears the held addresses.
    @(posedge clk_h); #1 rst_h = 1'b1;
    @(posedge clk_h); @(posedge clk_h); #1 rst_h = 1'b0;
    @(negedge clk_h);
    check_all_zero("idle_reset");

    run_xfer(1'b1, 6'd56, 8'hFE, 6'd2, 0, 0, '0, 0, -1, 0, 12);
    run_xfer(1'b0, 6'd3, 8'h40, 6'd1, 0, 0, '0, 2, 2, 3, 11);
    run_xfer(1'b1, 6'd7, 8'h33, 6'd0, 0, 0, '0, 0, -1, 0, 0);

    for (int t = 0; t < 6; t++)
      run_xfer(1'($urandom), 6'($urandom), 8'($urandom), 6'($urandom_range(1, 4)),
               1, 0, '0, 0, -1, 0, -1);

    // Reset while the second word of a line is presented.
    @(posedge clk_h); #1;
    start = 1'b1; mem_sel_in = 1'b0; latch_mem_addr = 6'd9; latch_sdram_addr = 8'h20;
    num_lines = 6'd2; memory1_ready = 1'b1; sdram_ready = 1'b1;
    @(posedge clk_h); #1 start = 1'b0;
    @(posedge clk_h); #1 mem_valid = 1'b1; mem_data_in = rand_line();
    @(posedge clk_h); #1 mem_valid = 1'b0;
    @(posedge clk_h); #1;
    @(negedge clk_h);
    check("rst_pre_word1", {sdram_enable, sdram_addr_out}, {2'b10, 8'h21});
    rst_h = 1'b1;
    @(posedge clk_h); #1 rst_h = 1'b0; mem_valid = 1'b1;
    @(negedge clk_h);
    check_all_zero("mid_reset");
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_h);
      check("post_reset_quiet", {done, busy, mem_enable, sdram_enable}, 6'b0);
    end
    quiet();
    $display("reset during word 1 handled, errors=%0d", errors);

    run_xfer(1'b0, 6'd12, 8'h80, 6'd1, 0, 0, '0, 0, -1, 0, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
